// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: DMA transfer sequencer behind the configuration register file.
// On a start edge it latches SRC/DST/LEN and copies LEN bytes word by word over
// a single ICB master port. Each chunk of up to BURST words is first read into
// an internal buffer, then written out, with one bus transaction outstanding.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   CTR               [0] enable, [1] irq enable
//   CR                [0] start (rising edge), [1] clear status (rising edge)
//   SRC_REG/DST_REG   source / destination byte address (word aligned)
//   LEN_REG           transfer length in bytes (multiple of 4)
//   SR                [0] done, [1] err, [2] busy, [3] align_err
//   dma_irq           level interrupt, CTR[1] & (done | err)
//   m_icb_*           ICB master command / response channels
module dma_xfer_ctrl #(
   parameter int BURST = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] CTR,
   input  logic [31:0] CR,
   input  logic [31:0] SRC_REG,
   input  logic [31:0] DST_REG,
   input  logic [31:0] LEN_REG,
   output logic [31:0] SR,
   output logic        dma_irq,
   output logic        m_icb_cmd_valid,
   output logic        m_icb_cmd_read,
   output logic [31:0] m_icb_cmd_addr,
   output logic [31:0] m_icb_cmd_wdata,
   output logic [3:0]  m_icb_cmd_wmask,
   input  logic        m_icb_cmd_ready,
   input  logic        m_icb_rsp_valid,
   input  logic [31:0] m_icb_rsp_rdata,
   input  logic        m_icb_rsp_err,
   output logic        m_icb_rsp_ready
);
   localparam int IW = $clog2(BURST);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t state, state_nxt;

   logic [1:0]            cr_q;
   logic                  sr_done, sr_err, sr_busy, sr_align;
   logic [31:0]           src_ptr, dst_ptr;
   logic [29:0]           words_left;
   logic [CW-1:0]         chunk;
   logic [IW-1:0]         idx;
   logic                  wait_rsp;   // command accepted, response pending
   logic [BURST-1:0][31:0] buf_q;

   logic        start_go, clr_go, bad_align, cmd_fire, rsp_fire, last_beat;
   logic [29:0] len_words, words_rem;
   logic        unused_bits;

   function automatic logic [CW-1:0] chunk_of(input logic [29:0] w);
      if (w >= 30'(BURST)) return CW'(BURST);
      return w[CW-1:0];
   endfunction

   assign unused_bits = ^{CTR[31:2], CR[31:2]};

   assign start_go  = CR[0] & ~cr_q[0] & (state == IDLE) & CTR[0];
   assign clr_go    = CR[1] & ~cr_q[1];
   assign bad_align = |{SRC_REG[1:0], DST_REG[1:0], LEN_REG[1:0]};
   assign len_words = LEN_REG[31:2];
   assign cmd_fire  = m_icb_cmd_valid & m_icb_cmd_ready;
   assign rsp_fire  = m_icb_rsp_valid & m_icb_rsp_ready;
   assign last_beat = ({1'b0, idx} == chunk - CW'(1));
   assign words_rem = words_left - 30'(chunk);

   assign SR      = {28'h0, sr_align, sr_busy, sr_err, sr_done};
   assign dma_irq = CTR[1] & (sr_done | sr_err);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Bus outputs are decoded purely from registered state, so an async reset
   // drops any partially issued command in the same cycle.
   always_comb begin
      state_nxt       = state;
      m_icb_cmd_valid = 1'b0;
      m_icb_cmd_read  = 1'b0;
      m_icb_cmd_addr  = 32'h0;
      m_icb_cmd_wdata = 32'h0;
      m_icb_cmd_wmask = 4'h0;
      m_icb_rsp_ready = 1'b0;
      case (state)
         IDLE: if (start_go && !bad_align && len_words != '0) state_nxt = RD;
         RD: begin
            m_icb_cmd_valid = ~wait_rsp;
            m_icb_cmd_read  = 1'b1;
            m_icb_cmd_addr  = src_ptr;
            m_icb_rsp_ready = wait_rsp;
            if (rsp_fire) begin
               if (m_icb_rsp_err)  state_nxt = IDLE;
               else if (last_beat) state_nxt = WR;
            end
         end
         WR: begin
            m_icb_cmd_valid = ~wait_rsp;
            m_icb_cmd_addr  = dst_ptr;
            m_icb_cmd_wdata = buf_q[idx];
            m_icb_cmd_wmask = 4'hF;
            m_icb_rsp_ready = wait_rsp;
            if (rsp_fire) begin
               if (m_icb_rsp_err)  state_nxt = IDLE;
               else if (last_beat) state_nxt = (words_rem == '0) ? DONE : RD;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cr_q       <= '0;
         sr_done    <= 1'b0;
         sr_err     <= 1'b0;
         sr_busy    <= 1'b0;
         sr_align   <= 1'b0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         words_left <= '0;
         chunk      <= '0;
         idx        <= '0;
         wait_rsp   <= 1'b0;
         buf_q      <= '0;
      end else begin
         cr_q <= CR[1:0];
         if (clr_go) begin
            sr_done  <= 1'b0;
            sr_err   <= 1'b0;
            sr_align <= 1'b0;
         end
         // Placed after the clear so a same-cycle start wins.
         if (start_go) begin
            sr_done  <= 1'b0;
            sr_err   <= 1'b0;
            sr_align <= 1'b0;
            if (bad_align) begin
               sr_err   <= 1'b1;
               sr_align <= 1'b1;
            end else if (len_words == '0) begin
               sr_done <= 1'b1;
            end else begin
               src_ptr    <= SRC_REG;
               dst_ptr    <= DST_REG;
               words_left <= len_words;
               chunk      <= chunk_of(len_words);
               idx        <= '0;
               sr_busy    <= 1'b1;
            end
         end
         if (cmd_fire) wait_rsp <= 1'b1;
         if (rsp_fire) begin
            wait_rsp <= 1'b0;
            if (m_icb_rsp_err) begin
               sr_busy <= 1'b0;
               sr_err  <= 1'b1;
               idx     <= '0;
            end else begin
               idx <= last_beat ? '0 : idx + IW'(1);
               if (state == RD) begin
                  buf_q[idx] <= m_icb_rsp_rdata;
                  src_ptr    <= src_ptr + 32'd4;
               end else begin
                  dst_ptr <= dst_ptr + 32'd4;
               end
               // End of a write chunk: either refill or finish. Done is set
               // together with the DONE state so it is visible during it.
               if (state == WR && last_beat) begin
                  words_left <= words_rem;
                  chunk      <= chunk_of(words_rem);
                  if (words_rem == '0) begin
                     sr_busy <= 1'b0;
                     sr_done <= 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: doc/dma_xfer_ctrl.md
Name: dma_xfer_ctrl

Overview:
- Transfer sequencer behind the DMA configuration register file.
- Latches SRC_REG, DST_REG and LEN_REG on a start request and moves LEN bytes from source to destination. It does this over one ICB master port, in chunks of up to BURST words, using an internal buffer.
- Reports busy, done and error status through SR and raises an interrupt on completion.

Parameters:
- BURST, 8, words per chunk and depth of the internal word buffer (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- CTR  in  32  control: [0] enable, [1] irq enable
- CR  in  32  command: [0] start (rising edge), [1] clear status (rising edge)
- SRC_REG  in  32  source byte address
- DST_REG  in  32  destination byte address
- LEN_REG  in  32  transfer length in bytes
- SR  out  32  status: [0] done, [1] err, [2] busy, [3] align_err; [31:4]=0
- dma_irq  out  1  level interrupt = CTR[1] & (SR[0] | SR[1])
- m_icb_cmd_valid  out  1  master command valid
- m_icb_cmd_read  out  1  1=read, 0=write
- m_icb_cmd_addr  out  32  word-aligned address
- m_icb_cmd_wdata  out  32  write data
- m_icb_cmd_wmask  out  4  always 4'hF on writes, 4'h0 on reads
- m_icb_cmd_ready  in  1  command accepted
- m_icb_rsp_valid  in  1  response valid
- m_icb_rsp_rdata  in  32  read data
- m_icb_rsp_err  in  1  bus error
- m_icb_rsp_ready  out  1  response ready

Behaviour:
- Reset: state IDLE, SR=0, dma_irq=0, cmd_valid=0, rsp_ready=0, all internal counters and pointers 0, previous-value registers for CR[1:0] = 0.
- Start: the rising edge of CR[0] (CR[0]=1 and its registered copy=0) while state=IDLE and CTR[0]=1.
  - Edges while busy or with CTR[0]=0 are ignored.
- Clear: the rising edge of CR[1] zeroes SR[0], SR[1] and SR[3]. It does not affect busy. A clear and a start in the same cycle: clear first, then start.
- On start:
  - Clear done/err/align_err.
  - If SRC[1:0], DST[1:0] or LEN[1:0] is nonzero: SR[1]=1 and SR[3]=1, no bus traffic, stay IDLE.
  - Else if LEN=0: SR[0]=1 next cycle, no bus traffic.
  - Else latch src_ptr=SRC, dst_ptr=DST, words_left=LEN>>2, set busy (SR[2]=1) and enter RD.
- RD:
  - chunk = min(BURST, words_left), fixed at entry.
  - Issue chunk reads one at a time: assert cmd_valid/read at src_ptr and hold until cmd_ready. Then drop cmd_valid and assert rsp_ready until rsp_valid.
  - Store rdata in buffer[idx] and set src_ptr += 4.
  - Only one outstanding transaction; the next command is issued in the cycle after the response handshake.
  - After the last response go to WR.
- WR:
  - Issue chunk writes from buffer[0..chunk-1] to dst_ptr (+4 each), with the same single-outstanding rule.
  - After the last response, words_left -= chunk. If 0, go to DONE; else go to RD.
- DONE (one cycle): busy=0, SR[0]=1, then IDLE.
- Bus error: rsp_valid & rsp_err in RD or WR aborts immediately.
  - busy=0, SR[1]=1, SR[0] stays 0, state IDLE, no further commands.
  - Pointers are not restored.
- cmd_valid, once asserted, must not drop, and addr/wdata must not change, until cmd_ready.
- Pointers wrap modulo 2^32. words_left is 30 bits.
- Busy rises the cycle after the start edge and falls the cycle after the final write response.
- CTR[0] dropping mid-transfer does not abort the transfer.
- Asynchronous reset mid-transfer returns everything to the reset values. A partially issued ICB command is dropped.

Test Plan:
- CTR=1, SRC=0x1000, DST=0x2000, LEN=16, memory words 0xA0..0xA3, cmd_ready=1, 1-cycle rsp -> 4 reads then 4 writes to 0x2000..0x200C carrying 0xA0..0xA3 with wmask=F. SR goes 0x4 -> 0x1; irq only when CTR[1]=1.
- LEN=40 with BURST=8 -> chunks of 8 then 2. Read/write order is R8,W8,R2,W2. Final dst address 0x2024. Done set once.
- SRC=0x1002, LEN=8 -> SR=0xA the cycle after start, no cmd_valid. A CR[1] edge returns SR to 0.
- rsp_err on the 3rd read response -> cmd_valid never reasserts, SR=0x2, dma_irq=1 with CTR[1]=1.
- cmd_ready held low for 5 cycles on the first write -> addr and wdata stable throughout. A second start edge during busy is ignored (exactly one done).
- rst_n asserted mid-WR -> all outputs 0 the same cycle. A new start after release runs a clean transfer.
